// File: rtl/result_drain_unit.sv
// Result drain unit: fetches result matrix C one row per read (all banks in parallel) into
// ping-pong row buffers and streams it row-major on a valid/ready port. Macro RESULT_DRAIN_REQUANT_EN adds int8 requantization.
module result_drain_unit #(
    parameter int N      = 16,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
`ifdef RESULT_DRAIN_REQUANT_EN
    input  logic [4:0]          i_requant_shift,
`endif
    output logic                o_busy,
    output logic                o_done,
    output logic                o_bram_c_rden,
    output logic [N*ADDR_W-1:0] o_bram_c_raddr,
    input  logic [N*DATA_W-1:0] i_bram_c_rdata,
    output logic                o_m_valid,
    input  logic                i_m_ready,
    output logic [DATA_W-1:0]   o_m_data,
    output logic                o_m_last,
    output logic                o_m_eor
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [DATA_W-1:0] r_buf [2][N];
    logic [1:0]        r_full;
    logic [1:0]        r_pend;
    logic              r_fillSel;
    logic              r_rdSel;
    logic              r_presSel;
    logic              r_capValid;
    logic              r_capSel;
    logic [RW-1:0]     r_fetchRow;
    logic [CW-1:0]     r_rdCol;
    logic [CW-1:0]     r_rdRow;
    logic              r_mValid;
    logic              r_mEor;
    logic              r_mLast;
    logic [DATA_W-1:0] r_mData;

    logic              w_startAcc;
    logic              w_handshake;
    logic              w_fetch;
    logic              w_load;
    logic              w_wrValid;
    logic              w_wrSel;
    logic [1:0]        w_freeMask;
    logic [1:0]        w_fetchMask;
    logic [1:0]        w_wrMask;
    logic [DATA_W-1:0] w_wrWord [N];

    assign w_startAcc  = (r_state == S_IDLE) && i_start;
    assign w_handshake = r_mValid && i_m_ready;
    // A buffer released by this cycle's end-of-row handshake may be refetched in the same cycle.
    assign w_freeMask  = (w_handshake && r_mEor) ? (2'b01 << r_presSel) : 2'b00;
    assign w_fetch     = (r_state == S_RUN) && (r_fetchRow < RW'(N))
                         && !(r_full[r_fillSel] && !w_freeMask[r_fillSel])
                         && !r_pend[r_fillSel];
    assign w_fetchMask = w_fetch ? (2'b01 << r_fillSel) : 2'b00;
    assign w_wrMask    = w_wrValid ? (2'b01 << w_wrSel) : 2'b00;
    assign w_load      = (!r_mValid || i_m_ready) && r_full[r_rdSel];

`ifdef RESULT_DRAIN_REQUANT_EN
    localparam logic signed [DATA_W:0] SAT_HI = 127;
    localparam logic signed [DATA_W:0] SAT_LO = -128;

    logic [4:0]          r_shift;
    logic                r_stageValid;
    logic                r_stageSel;
    logic [N*DATA_W-1:0] r_stageData;

    function automatic logic [DATA_W-1:0] requant(input logic [DATA_W-1:0] x, input logic [4:0] sh);
        logic signed [DATA_W:0] v;
        v = $signed({x[DATA_W-1], x});
        if (sh != 5'd0)
            v = v + ((DATA_W+1)'(1) << (sh - 5'd1));
        v = v >>> sh;
        if (v > SAT_HI)
            v = SAT_HI;
        else if (v < SAT_LO)
            v = SAT_LO;
        return {{(DATA_W-8){v[7]}}, v[7:0]};
    endfunction

    // Read data is registered once more so the shift/round/saturate path gets a full cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift      <= '0;
            r_stageValid <= 1'b0;
            r_stageSel   <= 1'b0;
            r_stageData  <= '0;
        end else begin
            if (w_startAcc)
                r_shift <= i_requant_shift;
            r_stageValid <= r_capValid;
            r_stageSel   <= r_capSel;
            if (r_capValid)
                r_stageData <= i_bram_c_rdata;
        end
    end

    assign w_wrValid = r_stageValid;
    assign w_wrSel   = r_stageSel;

    always_comb begin
        for (int k = 0; k < N; k++)
            w_wrWord[k] = requant(r_stageData[k*DATA_W +: DATA_W], r_shift);
    end
`else
    assign w_wrValid = r_capValid;
    assign w_wrSel   = r_capSel;

    always_comb begin
        for (int k = 0; k < N; k++)
            w_wrWord[k] = i_bram_c_rdata[k*DATA_W +: DATA_W];
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) w_nextState = S_RUN;
            S_RUN: begin
                o_busy = 1'b1;
                if (w_handshake && r_mLast)
                    w_nextState = S_DONE;
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wrValid)
            r_buf[w_wrSel] <= w_wrWord;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full     <= 2'b00;
            r_pend     <= 2'b00;
            r_fillSel  <= 1'b0;
            r_rdSel    <= 1'b0;
            r_presSel  <= 1'b0;
            r_capValid <= 1'b0;
            r_capSel   <= 1'b0;
            r_fetchRow <= '0;
            r_rdCol    <= '0;
            r_rdRow    <= '0;
            r_mValid   <= 1'b0;
            r_mEor     <= 1'b0;
            r_mLast    <= 1'b0;
            r_mData    <= '0;
        end else begin
            r_full     <= (r_full & ~w_freeMask) | w_wrMask;
            r_pend     <= (r_pend | w_fetchMask) & ~w_wrMask;
            r_capValid <= w_fetch;
            r_capSel   <= r_fillSel;
            if (w_startAcc) begin
                r_fetchRow <= '0;
                r_fillSel  <= 1'b0;
                r_rdSel    <= 1'b0;
                r_rdCol    <= '0;
                r_rdRow    <= '0;
            end else begin
                if (w_fetch) begin
                    r_fetchRow <= r_fetchRow + RW'(1);
                    r_fillSel  <= ~r_fillSel;
                end
                if (w_load) begin
                    if (r_rdCol == CW'(N-1)) begin
                        r_rdCol <= '0;
                        r_rdSel <= ~r_rdSel;
                        r_rdRow <= (r_rdRow == CW'(N-1)) ? '0 : r_rdRow + CW'(1);
                    end else begin
                        r_rdCol <= r_rdCol + CW'(1);
                    end
                end
            end
            // Output register refills whenever it is empty or being consumed this edge.
            if (w_load) begin
                r_mValid  <= 1'b1;
                r_mData   <= r_buf[r_rdSel][r_rdCol];
                r_mEor    <= (r_rdCol == CW'(N-1));
                r_mLast   <= (r_rdCol == CW'(N-1)) && (r_rdRow == CW'(N-1));
                r_presSel <= r_rdSel;
            end else if (w_handshake) begin
                r_mValid <= 1'b0;
                r_mEor   <= 1'b0;
                r_mLast  <= 1'b0;
            end
        end
    end

    assign o_bram_c_rden  = w_fetch;
    assign o_bram_c_raddr = {N{ADDR_W'(r_fetchRow)}};
    assign o_m_valid      = r_mValid;
    assign o_m_data       = r_mData;
    assign o_m_eor        = r_mEor;
    assign o_m_last       = r_mLast;

endmodule

// File: tb/tb_result_drain_unit.sv
// Self-checking bench for result_drain_unit: BRAM model, row-major word model and per-cycle stream monitor.
// Builds with or without RESULT_DRAIN_REQUANT_EN.
module tb_result_drain_unit;

    localparam int N      = 16;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
`ifdef RESULT_DRAIN_REQUANT_EN
    localparam int FIRST_LAT = 4;
`else
    localparam int FIRST_LAT = 3;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                i_start = 1'b0;
    logic                i_m_ready = 1'b0;
    logic [4:0]          i_requant_shift = 5'd4;
    logic                o_busy, o_done, o_bram_c_rden, o_m_valid, o_m_last, o_m_eor;
    logic [N*ADDR_W-1:0] o_bram_c_raddr;
    logic [N*DATA_W-1:0] i_bram_c_rdata = '0;
    logic [DATA_W-1:0]   o_m_data;

    logic [31:0] memC [N][N];
    int          modelShift = 4;

    int          checks = 0;
    int          errors = 0;
    int          expIdx = 0;
    int          rdenCount = 0;
    int          doneSeen = 0;
    int          bubbles = 0;
    int          eorSeen = 0;
    int          lastSeen = 0;
    int          cycleNo = 0;
    int          lastHsCycle = 0;
    bit          bubbleEn = 0;
    logic [31:0] lastWord = '0;
    logic [31:0] firstWords [4];
    logic        prevValid = 0, prevReady = 0, prevEor = 0, prevLast = 0;
    logic [31:0] prevData = '0;

    always #5 clk = ~clk;

    result_drain_unit #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
`ifdef RESULT_DRAIN_REQUANT_EN
        .i_requant_shift(i_requant_shift),
`endif
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_bram_c_rden  (o_bram_c_rden),
        .o_bram_c_raddr (o_bram_c_raddr),
        .i_bram_c_rdata (i_bram_c_rdata),
        .o_m_valid      (o_m_valid),
        .i_m_ready      (i_m_ready),
        .o_m_data       (o_m_data),
        .o_m_last       (o_m_last),
        .o_m_eor        (o_m_eor)
    );

    // Bank b returns C[row][b] one clock after the read request.
    always @(posedge clk) begin
        if (o_bram_c_rden) begin
            for (int b = 0; b < N; b++) begin
                int row;
                row = int'(o_bram_c_raddr[b*ADDR_W +: ADDR_W]);
                i_bram_c_rdata[b*DATA_W +: DATA_W] <= (row < N) ? memC[row][b] : 32'hBAD0BAD0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected stream word number idx, row-major over C.
    function automatic logic [31:0] modelWord(input int idx);
        logic [31:0] raw;
        raw = memC[idx / N][idx % N];
`ifdef RESULT_DRAIN_REQUANT_EN
        begin
            longint v;
            v = longint'($signed(raw));
            if (modelShift > 0)
                v = v + (longint'(1) << (modelShift - 1));
            v = v >>> modelShift;
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            return 32'(v);
        end
`else
        return raw;
`endif
    endfunction

    always @(negedge clk) begin
        cycleNo++;
        if (!rst) begin
            prevValid = 0;
        end else begin
            if (prevValid && !prevReady)
                checkOutput("stall_hold", 64'({o_m_valid, o_m_eor, o_m_last, o_m_data}),
                            64'({1'b1, prevEor, prevLast, prevData}));
            if (bubbleEn && expIdx > 0 && expIdx < N*N && !o_m_valid)
                bubbles++;
            if (o_m_valid && i_m_ready) begin
                if (expIdx < N*N)
                    checkOutput("word", 64'({o_m_eor, o_m_last, o_m_data}),
                                64'({(expIdx % N) == N-1, expIdx == N*N-1, modelWord(expIdx)}));
                else
                    checkOutput("extra_word", 64'(expIdx), 64'(N*N - 1));
                if (expIdx < 4)
                    firstWords[expIdx] = o_m_data;
                if (o_m_eor) eorSeen++;
                if (o_m_last) lastSeen++;
                lastWord    = o_m_data;
                lastHsCycle = cycleNo;
                expIdx++;
            end
            if (o_bram_c_rden) begin
                checkOutput("rden_addr", 64'(o_bram_c_raddr[63:0]), {8{8'(rdenCount)}});
                checkOutput("rden_addr_hi", 64'(o_bram_c_raddr[127:64]), {8{8'(rdenCount)}});
                rdenCount++;
            end
            if (o_done) begin
                doneSeen++;
                checkOutput("done_words", 64'(expIdx), 64'(N*N));
                checkOutput("done_timing", 64'(cycleNo - lastHsCycle), 64'd1);
                checkOutput("done_busy", 64'(o_busy), 64'd0);
            end
            prevValid = o_m_valid;
            prevReady = i_m_ready;
            prevEor   = o_m_eor;
            prevLast  = o_m_last;
            prevData  = o_m_data;
        end
    end

    task automatic checkAllZero(input string name);
        checkOutput({name, "_ctrl"}, 64'({o_busy, o_done, o_bram_c_rden, o_m_valid, o_m_last, o_m_eor}), 64'd0);
        checkOutput({name, "_data"}, 64'(o_m_data), 64'd0);
        checkOutput({name, "_raddr"}, 64'(|o_bram_c_raddr), 64'd0);
    endtask

    task automatic clearModel();
        expIdx    = 0;
        rdenCount = 0;
        bubbles   = 0;
        eorSeen   = 0;
        lastSeen  = 0;
    endtask

    // Pulse start for one sampling edge, then count edges until the first valid word.
    task automatic applyStimulus(output int lat);
        @(posedge clk); #2;
        i_start = 1'b1;
        i_requant_shift = 5'(modelShift);
        @(posedge clk); #2;
        i_start = 1'b0;
        i_requant_shift = 5'd0;
        lat = 0;
        while (!o_m_valid && lat < 20) begin
            @(posedge clk); #2;
            lat++;
        end
    endtask

    // mode 1 drives the ready pattern 1,0,0,1 repeatedly.
    task automatic runUntilDone(input int mode, input int budget, input string name);
        int base, k;
        base = doneSeen;
        k = 0;
        while (doneSeen == base && k < budget) begin
            @(posedge clk); #2;
            if (mode == 1)
                i_m_ready = ((k % 4) == 0) || ((k % 4) == 3);
            k++;
        end
        checkOutput(name, 64'(doneSeen - base), 64'd1);
    endtask

    task automatic waitWords(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (expIdx < target && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        checkOutput(name, 64'(expIdx >= target), 64'd1);
    endtask

    initial begin
        int lat, doneBase;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                memC[r][c] = 32'(r * 256 + c);
`ifdef RESULT_DRAIN_REQUANT_EN
        memC[0][0] = 32'h00000017;
        memC[0][1] = 32'h7FFFFFFF;
        memC[0][2] = 32'hFFFFFF00;
        memC[0][3] = 32'h00000008;
`endif

        repeat (3) @(posedge clk);
        #2;
        checkAllZero("in_reset");
        rst = 1'b1;
        @(posedge clk); #2;
        checkAllZero("idle");

        $display("[TB] unstalled drain");
        i_m_ready = 1'b1;
        clearModel();
        bubbleEn = 1;
        applyStimulus(lat);
        checkOutput("first_valid_lat", 64'(lat), 64'(FIRST_LAT));
        runUntilDone(0, 600, "done_a");
        checkOutput("words_a", 64'(expIdx), 64'(N*N));
        checkOutput("rden_a", 64'(rdenCount), 64'(N));
        checkOutput("bubbles_a", 64'(bubbles), 64'd0);
        checkOutput("eor_a", 64'(eorSeen), 64'(N));
        checkOutput("last_a", 64'(lastSeen), 64'd1);
`ifdef RESULT_DRAIN_REQUANT_EN
        checkOutput("rq_word0", 64'(firstWords[0]), 64'h1);
        checkOutput("rq_word1", 64'(firstWords[1]), 64'd127);
        checkOutput("rq_word2", 64'(firstWords[2]), 64'hFFFFFFF0);
        checkOutput("rq_word3", 64'(firstWords[3]), 64'h1);
`else
        checkOutput("word1_lit", 64'(firstWords[1]), 64'h1);
        checkOutput("word3_lit", 64'(firstWords[3]), 64'h3);
        checkOutput("last_word_lit", 64'(lastWord), 64'h0F0F);
`endif
        @(posedge clk); #2;
        checkOutput("idle_after_a", 64'({o_busy, o_done, o_m_valid}), 64'd0);

        $display("[TB] ready pattern 1,0,0,1");
        bubbleEn = 0;
        clearModel();
        applyStimulus(lat);
        runUntilDone(1, 2000, "done_b");
        checkOutput("words_b", 64'(expIdx), 64'(N*N));
        checkOutput("rden_b", 64'(rdenCount), 64'(N));

        $display("[TB] long initial stall");
        i_m_ready = 1'b0;
        clearModel();
        applyStimulus(lat);
        repeat (40) @(posedge clk);
        #2;
        checkOutput("rden_stalled", 64'(rdenCount), 64'd2);
        checkOutput("valid_stalled", 64'(o_m_valid), 64'd1);
        i_m_ready = 1'b1;
        bubbleEn = 1;
        runUntilDone(0, 600, "done_c");
        checkOutput("words_c", 64'(expIdx), 64'(N*N));
        checkOutput("bubbles_c", 64'(bubbles), 64'd0);
        checkOutput("rden_c", 64'(rdenCount), 64'(N));

        $display("[TB] restart ignored, reset abort");
        bubbleEn = 0;
        clearModel();
        doneBase = doneSeen;
        applyStimulus(lat);
        waitWords(50, 600, "reach_50");
        i_start = 1'b1;
        @(posedge clk); #2;
        i_start = 1'b0;
        waitWords(100, 600, "reach_100");
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("abort");
        repeat (5) @(posedge clk);
        #2;
        checkAllZero("abort_hold");
        checkOutput("no_done_abort", 64'(doneSeen - doneBase), 64'd0);
        clearModel();
        rst = 1'b1;
        applyStimulus(lat);
        checkOutput("first_valid_lat_d", 64'(lat), 64'(FIRST_LAT));
        runUntilDone(0, 600, "done_d");
        checkOutput("words_d", 64'(expIdx), 64'(N*N));
        checkOutput("rden_d", 64'(rdenCount), 64'(N));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
